// File: rtl/ps_fold.sv
// Folded ASCON substitution layer: SBOX_PER_CYCLE S-boxes swept across the 64 columns
// of a 320-bit state. The inverse S-box mode exists only when PS_FOLD_INV_EN is defined.
//
//   state  | meaning
//   IDLE   | ready for a new state; st holds the previous result
//   RUN    | substituting group cnt of columns in place, one group per cycle
//   DONE   | result valid, held until the downstream accepts it
module ps_fold #(
  parameter int SBOX_PER_CYCLE = 8
) (
  input  logic             clock_i,
  input  logic             resetb_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [4:0][63:0] ps_i,
`ifdef PS_FOLD_INV_EN
  input  logic             inv_i,
`endif
  output logic             valid_o,
  input  logic             ready_i,
  output logic [4:0][63:0] ps_o,
  output logic             busy_o
);

  localparam int NB_STEPS = (SBOX_PER_CYCLE > 0) ? 64 / SBOX_PER_CYCLE : 1;
  localparam int CNT_W    = (NB_STEPS > 1) ? $clog2(NB_STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NB_STEPS - 1);
  localparam logic [63:0] GRP_MASK = {64{1'b1}} >> (64 - SBOX_PER_CYCLE);

  if ((SBOX_PER_CYCLE < 1) || (SBOX_PER_CYCLE > 64) ||
      ((SBOX_PER_CYCLE & (SBOX_PER_CYCLE - 1)) != 0)) begin : g_bad_param
    $error("ps_fold: SBOX_PER_CYCLE must be a power of 2 in 1..64");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [4:0][63:0]        st_q, st_d;
  logic [5:0]              base;
  logic [4:0][SBOX_PER_CYCLE-1:0] grp_in, grp_out;
  logic [SBOX_PER_CYCLE-1:0][4:0] col_out;

  function automatic logic [4:0] sbox_fwd(input logic [4:0] x);
    logic [4:0] y;
    case (x)
      5'h00: y = 5'h04;  5'h01: y = 5'h0b;  5'h02: y = 5'h1f;  5'h03: y = 5'h14;
      5'h04: y = 5'h1a;  5'h05: y = 5'h15;  5'h06: y = 5'h09;  5'h07: y = 5'h02;
      5'h08: y = 5'h1b;  5'h09: y = 5'h05;  5'h0a: y = 5'h08;  5'h0b: y = 5'h12;
      5'h0c: y = 5'h1d;  5'h0d: y = 5'h03;  5'h0e: y = 5'h06;  5'h0f: y = 5'h1c;
      5'h10: y = 5'h1e;  5'h11: y = 5'h13;  5'h12: y = 5'h07;  5'h13: y = 5'h0e;
      5'h14: y = 5'h00;  5'h15: y = 5'h0d;  5'h16: y = 5'h11;  5'h17: y = 5'h18;
      5'h18: y = 5'h10;  5'h19: y = 5'h0c;  5'h1a: y = 5'h01;  5'h1b: y = 5'h19;
      5'h1c: y = 5'h16;  5'h1d: y = 5'h0a;  5'h1e: y = 5'h0f;  default: y = 5'h17;
    endcase
    return y;
  endfunction

`ifdef PS_FOLD_INV_EN
  logic inv_q, inv_d;

  function automatic logic [4:0] sbox_inv(input logic [4:0] x);
    logic [4:0] y;
    case (x)
      5'h00: y = 5'h14;  5'h01: y = 5'h1a;  5'h02: y = 5'h07;  5'h03: y = 5'h0d;
      5'h04: y = 5'h00;  5'h05: y = 5'h09;  5'h06: y = 5'h0e;  5'h07: y = 5'h12;
      5'h08: y = 5'h0a;  5'h09: y = 5'h06;  5'h0a: y = 5'h1d;  5'h0b: y = 5'h01;
      5'h0c: y = 5'h19;  5'h0d: y = 5'h15;  5'h0e: y = 5'h13;  5'h0f: y = 5'h1e;
      5'h10: y = 5'h18;  5'h11: y = 5'h16;  5'h12: y = 5'h0b;  5'h13: y = 5'h11;
      5'h14: y = 5'h03;  5'h15: y = 5'h05;  5'h16: y = 5'h1c;  5'h17: y = 5'h1f;
      5'h18: y = 5'h17;  5'h19: y = 5'h1b;  5'h1a: y = 5'h04;  5'h1b: y = 5'h08;
      5'h1c: y = 5'h0f;  5'h1d: y = 5'h0c;  5'h1e: y = 5'h10;  default: y = 5'h02;
    endcase
    return y;
  endfunction
`endif

  // First column of the group handled this step; always below 64.
  assign base = 6'(int'(cnt_q) * SBOX_PER_CYCLE);

  always_comb begin
    grp_in  = '0;
    grp_out = '0;
    col_out = '0;
    for (int w = 0; w < 5; w++) begin
      grp_in[w] = SBOX_PER_CYCLE'(st_q[w] >> base);
    end
    for (int j = 0; j < SBOX_PER_CYCLE; j++) begin
`ifdef PS_FOLD_INV_EN
      if (inv_q) begin
        col_out[j] = sbox_inv({grp_in[0][j], grp_in[1][j], grp_in[2][j], grp_in[3][j], grp_in[4][j]});
      end else begin
        col_out[j] = sbox_fwd({grp_in[0][j], grp_in[1][j], grp_in[2][j], grp_in[3][j], grp_in[4][j]});
      end
`else
      col_out[j] = sbox_fwd({grp_in[0][j], grp_in[1][j], grp_in[2][j], grp_in[3][j], grp_in[4][j]});
`endif
      for (int w = 0; w < 5; w++) begin
        grp_out[w][j] = col_out[j][4-w];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    st_d    = st_q;
`ifdef PS_FOLD_INV_EN
    inv_d   = inv_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (valid_i) begin
          st_d    = ps_i;
          cnt_d   = '0;
          state_d = S_RUN;
`ifdef PS_FOLD_INV_EN
          inv_d   = inv_i;
`endif
        end
      end
      S_RUN: begin
        for (int w = 0; w < 5; w++) begin
          st_d[w] = (st_q[w] & ~(GRP_MASK << base)) | (64'(grp_out[w]) << base);
        end
        if (cnt_q == LAST_STEP) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        if (ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (!resetb_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      st_q    <= '0;
`ifdef PS_FOLD_INV_EN
      inv_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      st_q    <= st_d;
`ifdef PS_FOLD_INV_EN
      inv_q   <= inv_d;
`endif
    end
  end

  // Handshake outputs come from the state register alone.
  assign ready_o = (state_q == S_IDLE);
  assign valid_o = (state_q == S_DONE);
  assign busy_o  = (state_q == S_RUN) || (state_q == S_DONE);
  assign ps_o    = st_q;

endmodule

// File: tb/tb_ps_fold.sv
// Self-checking bench for ps_fold: three instances (1, 8 and 64 S-boxes per cycle) share
// one input bus and are checked every cycle against a whole-state substitution-layer model.
module tb_ps_fold;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             resetb;
  logic [4:0][63:0] ps_in;
`ifdef PS_FOLD_INV_EN
  logic             inv_in;
`endif
  logic             valid_x [3];
  logic             rdy_x   [3];
  logic             vo [3];
  logic             ro [3];
  logic             bo [3];
  logic [4:0][63:0] pso [3];

  localparam int NBS [3] = '{64, 8, 1};
  localparam logic [4:0] FWD [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  ps_fold #(.SBOX_PER_CYCLE(1)) u_s1 (
    .clock_i(clk), .resetb_i(resetb), .valid_i(valid_x[0]), .ready_o(ro[0]), .ps_i(ps_in),
`ifdef PS_FOLD_INV_EN
    .inv_i(inv_in),
`endif
    .valid_o(vo[0]), .ready_i(rdy_x[0]), .ps_o(pso[0]), .busy_o(bo[0]));

  ps_fold #(.SBOX_PER_CYCLE(8)) u_s8 (
    .clock_i(clk), .resetb_i(resetb), .valid_i(valid_x[1]), .ready_o(ro[1]), .ps_i(ps_in),
`ifdef PS_FOLD_INV_EN
    .inv_i(inv_in),
`endif
    .valid_o(vo[1]), .ready_i(rdy_x[1]), .ps_o(pso[1]), .busy_o(bo[1]));

  ps_fold #(.SBOX_PER_CYCLE(64)) u_s64 (
    .clock_i(clk), .resetb_i(resetb), .valid_i(valid_x[2]), .ready_o(ro[2]), .ps_i(ps_in),
`ifdef PS_FOLD_INV_EN
    .inv_i(inv_in),
`endif
    .valid_o(vo[2]), .ready_i(rdy_x[2]), .ps_o(pso[2]), .busy_o(bo[2]));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int k, input logic [319:0] act, input logic [319:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %h want %h", nm, k, act, exp);
    end
  endtask

  // Whole-state reference: every column substituted at once.
  function automatic logic [4:0][63:0] layer(input logic [4:0][63:0] s, input bit inv);
    logic [4:0][63:0] r;
    logic [4:0] c, o;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      c = {s[0][i], s[1][i], s[2][i], s[3][i], s[4][i]};
      o = FWD[c];
      if (inv) begin
        for (int v = 0; v < 32; v++) if (FWD[v] == c) o = 5'(v);
      end
      for (int w = 0; w < 5; w++) r[w][i] = o[4-w];
    end
    return r;
  endfunction

  function automatic logic [4:0][63:0] rnd_state();
    logic [4:0][63:0] r;
    for (int w = 0; w < 5; w++) r[w] = {$urandom, $urandom};
    return r;
  endfunction

  function automatic bit cur_inv();
`ifdef PS_FOLD_INV_EN
    return inv_in;
`else
    return 1'b0;
`endif
  endfunction

  // Cycle model per instance: pending op, edges since accept, expected state register.
  bit               known = 1'b0;
  bit               pending [3];
  int               age [3];
  logic [4:0][63:0] cur [3];

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (known) begin
        chk("ready_o", k, 320'(ro[k]), 320'(!pending[k]));
        chk("busy_o",  k, 320'(bo[k]), 320'(pending[k]));
        chk("valid_o", k, 320'(vo[k]), 320'(pending[k] && age[k] >= NBS[k]));
        if (!pending[k] || age[k] >= NBS[k]) chk("ps_o", k, pso[k], cur[k]);
      end
      if (!resetb) begin
        pending[k] = 1'b0;
        age[k]     = 0;
        cur[k]     = '0;
      end else if (!pending[k]) begin
        if (valid_x[k]) begin
          pending[k] = 1'b1;
          age[k]     = 0;
          cur[k]     = layer(ps_in, cur_inv());
        end
      end else if (age[k] >= NBS[k]) begin
        if (rdy_x[k]) pending[k] = 1'b0;
      end else begin
        age[k]++;
      end
    end
    if (!resetb) known = 1'b1;
  end

  logic [4:0][63:0] got [3];
  int               lat [3];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit all_seen();
    return (lat[0] != 0) && (lat[1] != 0) && (lat[2] != 0);
  endfunction

  // One operation on all instances; new data is thrown at them while they are busy.
  task automatic run_all(input logic [4:0][63:0] s);
    int n;
    for (int k = 0; k < 3; k++) begin
      lat[k] = 0;
      valid_x[k] = 1'b1;
      rdy_x[k] = 1'b0;
    end
    ps_in = s;
    tick();
    n = 1;
    for (int k = 0; k < 3; k++) valid_x[k] = 1'b0;
    for (int k = 0; k < 3; k++) if (vo[k] && lat[k] == 0) begin lat[k] = n; got[k] = pso[k]; end
    while (n < 200 && !all_seen()) begin
      ps_in = rnd_state();
      for (int k = 0; k < 3; k++) valid_x[k] = 1'($urandom_range(0, 1));
`ifdef PS_FOLD_INV_EN
      inv_in = 1'($urandom_range(0, 1));
`endif
      tick();
      n++;
      for (int k = 0; k < 3; k++) if (vo[k] && lat[k] == 0) begin lat[k] = n; got[k] = pso[k]; end
    end
    if (!all_seen()) begin
      n_cmp++;
      n_bad++;
      $display("FAIL run_timeout: got valid_o %0d%0d%0d want 111 within 200 cycles", vo[0], vo[1], vo[2]);
    end
    for (int k = 0; k < 3; k++) begin valid_x[k] = 1'b0; rdy_x[k] = 1'b1; end
    tick();
    for (int k = 0; k < 3; k++) rdy_x[k] = 1'b0;
  endtask

  logic [4:0][63:0] e_zero, e_ones, s_col, e_col, s_rand, r_fwd;

  initial begin
    resetb = 1'b0;
    ps_in  = '0;
`ifdef PS_FOLD_INV_EN
    inv_in = 1'b0;
`endif
    for (int k = 0; k < 3; k++) begin valid_x[k] = 1'b0; rdy_x[k] = 1'b0; end
    repeat (3) tick();
    resetb = 1'b1;

    for (int k = 0; k < 3; k++) begin
      chk("rst_ready", k, 320'(ro[k]), 320'(1));
      chk("rst_valid", k, 320'(vo[k]), 320'(0));
      chk("rst_busy",  k, 320'(bo[k]), 320'(0));
      chk("rst_state", k, pso[k], 320'(0));
    end

    e_zero = '0;  e_zero[2] = '1;
    e_ones = '1;  e_ones[1] = '0;
    s_col  = '0;  s_col[4][0] = 1'b1;
    e_col  = '0;  e_col[2] = ~64'h1;  e_col[1][0] = 1'b1;  e_col[3][0] = 1'b1;  e_col[4][0] = 1'b1;
    chk("model_zero", 0, layer('0, 1'b0), e_zero);
    chk("model_ones", 0, layer('1, 1'b0), e_ones);
    chk("model_col",  0, layer(s_col, 1'b0), e_col);

    run_all('0);
    for (int k = 0; k < 3; k++) begin
      chk("zero_result", k, got[k], e_zero);
      chk("latency", k, 320'(lat[k]), 320'(NBS[k] + 1));
    end
    run_all('1);
    for (int k = 0; k < 3; k++) chk("ones_result", k, got[k], e_ones);
    run_all(s_col);
    for (int k = 0; k < 3; k++) chk("col_result", k, got[k], e_col);

    // Abort an operation when the 8-wide instance sits at step 3.
    ps_in = rnd_state();
    for (int k = 0; k < 3; k++) valid_x[k] = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) valid_x[k] = 1'b0;
    repeat (3) tick();
    resetb = 1'b0;
    tick();
    resetb = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("abort_ready", k, 320'(ro[k]), 320'(1));
      chk("abort_valid", k, 320'(vo[k]), 320'(0));
      chk("abort_busy",  k, 320'(bo[k]), 320'(0));
    end
    s_rand = rnd_state();
    run_all(s_rand);
    for (int k = 0; k < 3; k++) chk("after_abort", k, got[k], layer(s_rand, 1'b0));

`ifdef PS_FOLD_INV_EN
    s_rand = rnd_state();
    inv_in = 1'b0;
    run_all(s_rand);
    r_fwd = got[1];
    inv_in = 1'b1;
    run_all(r_fwd);
    for (int k = 0; k < 3; k++) chk("inv_restore", k, got[k], s_rand);
    inv_in = 1'b0;
`else
    r_fwd = '0;
`endif

    for (int c = 0; c < 4000; c++) begin
      resetb = ($urandom_range(0, 299) != 0);
      ps_in  = rnd_state();
`ifdef PS_FOLD_INV_EN
      inv_in = 1'($urandom_range(0, 1));
`endif
      for (int k = 0; k < 3; k++) begin
        valid_x[k] = 1'($urandom_range(0, 1));
        rdy_x[k]   = ($urandom_range(0, 2) == 0);
      end
      tick();
    end

    resetb = 1'b1;
    for (int k = 0; k < 3; k++) begin valid_x[k] = 1'b0; rdy_x[k] = 1'b1; end
    repeat (100) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
